// File: rtl/ram_bus_pkg.sv
// ram_bus_pkg: state, size and owner encodings shared by the RAM bus
// controller and its arbiter.
package ram_bus_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PRIME,
      XFER,
      TAIL,
      DONE
   } state_t;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_LS = 1'b1
   } owner_t;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;

   // Index of the last byte of an access: 0 for bytes, 1 for halves, 3 for words.
   function automatic logic [1:0] size_last_idx(input logic [1:0] size);
      case (size)
         SZ_B:    size_last_idx = 2'd0;
         SZ_H:    size_last_idx = 2'd1;
         SZ_W:    size_last_idx = 2'd3;
         default: size_last_idx = 2'd3;
      endcase
   endfunction

endpackage

// File: rtl/ram_bus_arb.sv
// ram_bus_arb: picks which requester (IF or LSU) owns the next RAM transfer.
// Build option RAM_BUS_RR_EN: round-robin on simultaneous requests instead of
// fixed LSU priority; without it the last_grant register does not exist.
module ram_bus_arb
   import ram_bus_pkg::*;
(
   input  logic   clk_in,
   input  logic   rst_in,
   input  logic   if_req,
   input  logic   ls_req,
   input  logic   take,
   output logic   grant_valid,
   output owner_t grant_owner
);

`ifdef RAM_BUS_RR_EN
   owner_t last_grant;
`else
   logic unused_arb_inputs;
   assign unused_arb_inputs = clk_in ^ rst_in ^ take;
`endif

   // Grant selection: any request is valid, contention resolved by policy.
   always_comb begin
      grant_valid = if_req | ls_req;
      grant_owner = OWN_IF;
`ifdef RAM_BUS_RR_EN
      if (if_req && ls_req) begin
         grant_owner = (last_grant == OWN_IF) ? OWN_LS : OWN_IF;
      end else if (ls_req) begin
         grant_owner = OWN_LS;
      end
`else
      if (ls_req) begin
         grant_owner = OWN_LS;
      end
`endif
   end

`ifdef RAM_BUS_RR_EN
   // Remember who won the most recent grant so the other side wins the next tie.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         last_grant <= OWN_IF;
      end else if (take && grant_valid) begin
         last_grant <= grant_owner;
      end
   end
`endif

endmodule

// File: rtl/ram_bus_ctrl.sv
// ram_bus_ctrl: byte-serial controller sharing the 8-bit RAM between the
// instruction fetch unit and the load/store unit. Splits 1/2/4-byte accesses
// into little-endian byte cycles and reassembles read words.
// Build option RAM_BUS_RR_EN selects round-robin arbitration (see ram_bus_arb).
module ram_bus_ctrl #(
   parameter int ADDR_WIDTH = 17
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  if_req_in,
   input  logic [ADDR_WIDTH-1:0] if_addr_in,
   input  logic                  if_clr_in,
   output logic                  if_done_out,
   output logic [31:0]           if_data_out,
   input  logic                  ls_req_in,
   input  logic                  ls_wr_in,
   input  logic [1:0]            ls_size_in,
   input  logic [ADDR_WIDTH-1:0] ls_addr_in,
   input  logic [31:0]           ls_wdata_in,
   output logic                  ls_done_out,
   output logic [31:0]           ls_rdata_out,
   output logic                  ram_en_out,
   output logic                  ram_r_nw_out,
   output logic [ADDR_WIDTH-1:0] ram_a_out,
   output logic [7:0]            ram_d_out,
   input  logic [7:0]            ram_d_in
);
   import ram_bus_pkg::*;

   state_t                state_q;
   state_t                state_d;
   owner_t                owner_q;
   logic                  wr_q;
   logic [1:0]            last_q;
   logic [1:0]            k_q;
   logic [ADDR_WIDTH-1:0] base_q;
   logic [ADDR_WIDTH-1:0] addr_k;
   logic [31:0]           wdata_q;
   logic [31:0]           data_q;
   logic                  grant_valid;
   owner_t                grant_owner;
   logic                  grant_wr;
   logic                  if_req_eff;
   logic                  if_clr_owned;
   logic                  grant_take;

   // A flush in the same cycle as an IF request cancels that request.
   assign if_req_eff   = if_req_in & ~if_clr_in;
   assign grant_wr     = (grant_owner == OWN_LS) & ls_wr_in;
   assign grant_take   = (state_q == IDLE) & ~rst_in;
   assign if_clr_owned = (owner_q == OWN_IF) & if_clr_in;
   assign addr_k       = base_q + ADDR_WIDTH'(k_q);

   // Read data is presented only to the port that owns the current transfer.
   assign if_data_out  = (owner_q == OWN_IF) ? data_q : 32'h0;
   assign ls_rdata_out = (owner_q == OWN_LS) ? data_q : 32'h0;

   ram_bus_arb u_arb (
      .clk_in      (clk_in),
      .rst_in      (rst_in),
      .if_req      (if_req_eff),
      .ls_req      (ls_req_in),
      .take        (grant_take),
      .grant_valid (grant_valid),
      .grant_owner (grant_owner)
   );

   // Next state and RAM pin drive. While reset is asserted the pins are held
   // idle so a write byte in flight is not committed at the resetting edge.
   always_comb begin
      state_d      = state_q;
      ram_en_out   = 1'b0;
      ram_r_nw_out = 1'b1;
      ram_a_out    = '0;
      ram_d_out    = 8'h00;
      if_done_out  = 1'b0;
      ls_done_out  = 1'b0;
      if (!rst_in) begin
         case (state_q)
            IDLE: begin
               if (grant_valid) begin
                  state_d = grant_wr ? PRIME : XFER;
               end
            end
            PRIME: begin
               ram_en_out = 1'b1;
               ram_a_out  = base_q;
               state_d    = XFER;
            end
            XFER: begin
               ram_en_out = 1'b1;
               ram_a_out  = addr_k;
               if (wr_q) begin
                  ram_r_nw_out = 1'b0;
                  ram_d_out    = wdata_q[{k_q, 3'b000} +: 8];
               end
               if (k_q == last_q) begin
                  state_d = wr_q ? DONE : TAIL;
               end
               if (if_clr_owned) begin
                  state_d = IDLE;
               end
            end
            TAIL: begin
               state_d = if_clr_owned ? IDLE : DONE;
            end
            DONE: begin
               state_d = IDLE;
               if (owner_q == OWN_LS) begin
                  ls_done_out = 1'b1;
               end else begin
                  if_done_out = ~if_clr_in;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // State register, command latch on grant, byte counter and read assembly.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q <= IDLE;
         owner_q <= OWN_IF;
         wr_q    <= 1'b0;
         last_q  <= 2'd0;
         k_q     <= 2'd0;
         base_q  <= '0;
         wdata_q <= 32'h0;
         data_q  <= 32'h0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (grant_valid) begin
                  owner_q <= grant_owner;
                  wr_q    <= grant_wr;
                  k_q     <= 2'd0;
                  data_q  <= 32'h0;
                  if (grant_owner == OWN_LS) begin
                     last_q  <= size_last_idx(ls_size_in);
                     base_q  <= ls_addr_in;
                     wdata_q <= ls_wdata_in;
                  end else begin
                     last_q  <= 2'd3;
                     base_q  <= if_addr_in;
                     wdata_q <= 32'h0;
                  end
               end
            end
            XFER: begin
               k_q <= k_q + 2'd1;
               if (!wr_q && (k_q != 2'd0)) begin
                  data_q[{k_q - 2'd1, 3'b000} +: 8] <= ram_d_in;
               end
            end
            TAIL: begin
               data_q[{last_q, 3'b000} +: 8] <= ram_d_in;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ram_bus_ctrl.sv
// tb_ram_bus_ctrl: scoreboard bench for ram_bus_ctrl with a behavioural
// byte-wide RAM. Define RAM_BUS_RR_EN for both bench and RTL to check the
// round-robin build.
module tb_ram_bus_ctrl;

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b1;
   logic        if_req_in = 1'b0;
   logic [16:0] if_addr_in = '0;
   logic        if_clr_in = 1'b0;
   logic        if_done_out;
   logic [31:0] if_data_out;
   logic        ls_req_in = 1'b0;
   logic        ls_wr_in = 1'b0;
   logic [1:0]  ls_size_in = 2'd0;
   logic [16:0] ls_addr_in = '0;
   logic [31:0] ls_wdata_in = '0;
   logic        ls_done_out;
   logic [31:0] ls_rdata_out;
   logic        ram_en_out;
   logic        ram_r_nw_out;
   logic [16:0] ram_a_out;
   logic [7:0]  ram_d_out;
   logic [7:0]  ram_d_in = 8'h00;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   typedef struct {
      logic        own_ls;
      logic [31:0] data;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_exp;

   logic [7:0]  mem [0:(1 << 17) - 1];
   logic        en_prev = 1'b0;
   logic        bd_we = 1'b0;
   logic [16:0] bd_addr = '0;
   logic [7:0]  bd_data = 8'h00;

   ram_bus_ctrl #(.ADDR_WIDTH(17)) dut (
      .clk_in       (clk_in),
      .rst_in       (rst_in),
      .if_req_in    (if_req_in),
      .if_addr_in   (if_addr_in),
      .if_clr_in    (if_clr_in),
      .if_done_out  (if_done_out),
      .if_data_out  (if_data_out),
      .ls_req_in    (ls_req_in),
      .ls_wr_in     (ls_wr_in),
      .ls_size_in   (ls_size_in),
      .ls_addr_in   (ls_addr_in),
      .ls_wdata_in  (ls_wdata_in),
      .ls_done_out  (ls_done_out),
      .ls_rdata_out (ls_rdata_out),
      .ram_en_out   (ram_en_out),
      .ram_r_nw_out (ram_r_nw_out),
      .ram_a_out    (ram_a_out),
      .ram_d_out    (ram_d_out),
      .ram_d_in     (ram_d_in)
   );

   always #5 clk_in = ~clk_in;

   always @(posedge clk_in) cyc <= cyc + 1;

   // RAM model: read data one cycle after an enabled address, write commits
   // when the enable was high in the previous cycle; backdoor preload wins.
   always @(posedge clk_in) begin
      if (bd_we) begin
         mem[bd_addr] <= bd_data;
      end else if (en_prev && !ram_r_nw_out) begin
         mem[ram_a_out] <= ram_d_out;
      end
      if (ram_en_out) begin
         ram_d_in <= mem[ram_a_out];
      end
      en_prev <= ram_en_out;
   end

   // Scoreboard: every done pulse pops the oldest expected completion.
   always @(negedge clk_in) begin
      if (if_done_out || ls_done_out) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL sb_unexpected_done: got if_done=%0b ls_done=%0b, want no done", if_done_out, ls_done_out);
         end else begin
            mon_exp = exp_q.pop_front();
            if ({if_done_out, ls_done_out} !== (mon_exp.own_ls ? 2'b01 : 2'b10) ||
                (mon_exp.own_ls ? ls_rdata_out : if_data_out) !== mon_exp.data) begin
               errors++;
               $display("[TB] FAIL sb_done: got if_done=%0b ls_done=%0b if_data=%h ls_data=%h, want own_ls=%0b data=%h",
                        if_done_out, ls_done_out, if_data_out, ls_rdata_out, mon_exp.own_ls, mon_exp.data);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic poke(input logic [16:0] addr, input logic [7:0] data);
      bd_we   = 1'b1;
      bd_addr = addr;
      bd_data = data;
      @(negedge clk_in);
      bd_we   = 1'b0;
   endtask

   task automatic applyStimulus(input bit is_ls, input bit wr, input logic [1:0] size,
                                input logic [16:0] addr, input logic [31:0] wdata);
      if (is_ls) begin
         ls_req_in   = 1'b1;
         ls_wr_in    = wr;
         ls_size_in  = size;
         ls_addr_in  = addr;
         ls_wdata_in = wdata;
      end else begin
         if_req_in   = 1'b1;
         if_addr_in  = addr;
      end
   endtask

   task automatic wait_done(input int budget, output int at);
      at = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk_in);
         if (if_done_out || ls_done_out) begin
            at = cyc;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_in = 1'b1;
      @(negedge clk_in);
      @(negedge clk_in);
      checks++;
      if ({ram_en_out, ram_r_nw_out} !== 2'b01) begin
         errors++;
         $display("[TB] FAIL reset_en_rnw: got %b want 01", {ram_en_out, ram_r_nw_out});
      end
      checks++;
      if ({ram_a_out, ram_d_out} !== 25'h0) begin
         errors++;
         $display("[TB] FAIL reset_addr_data: got a=%h d=%h want 0", ram_a_out, ram_d_out);
      end
      checks++;
      if ({if_done_out, ls_done_out, if_data_out, ls_rdata_out} !== 66'h0) begin
         errors++;
         $display("[TB] FAIL reset_cpu_side: got done=%b%b if=%h ls=%h want 0", if_done_out, ls_done_out, if_data_out, ls_rdata_out);
      end
      rst_in = 1'b0;
      @(negedge clk_in);
   endtask

   task automatic test_if_read();
      int c0;
      int at;
      logic [16:0] ea;
      poke(17'h10, 8'h13);
      poke(17'h11, 8'h05);
      poke(17'h12, 8'h00);
      poke(17'h13, 8'h00);
      exp_q.push_back('{1'b0, 32'h0000_0513});
      applyStimulus(1'b0, 1'b0, 2'd0, 17'h10, 32'h0);
      c0 = cyc;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk_in);
         ea = 17'(32'h10 + k);
         checks++;
         if ({ram_en_out, ram_r_nw_out, ram_a_out} !== {2'b11, ea}) begin
            errors++;
            $display("[TB] FAIL if_read_addr k=%0d: got en=%b rnw=%b a=%h want en=1 rnw=1 a=%h", k, ram_en_out, ram_r_nw_out, ram_a_out, ea);
         end
      end
      wait_done(10, at);
      if_req_in = 1'b0;
      checks++;
      if (at != c0 + 6) begin
         errors++;
         $display("[TB] FAIL if_read_latency: got cycle %0d want %0d", at - c0, 6);
      end
      @(negedge clk_in);
   endtask

   task automatic test_write_wrap();
      int c0;
      int at;
      logic [16:0] ea;
      logic [7:0]  eb;
      logic [31:0] wd;
      wd = 32'hDEAD_BEEF;
      for (int k = 0; k < 4; k++) poke(17'(32'h1FFFE + k), 8'h00);
      exp_q.push_back('{1'b1, 32'h0});
      applyStimulus(1'b1, 1'b1, 2'd2, 17'h1FFFE, wd);
      c0 = cyc;
      @(negedge clk_in);
      checks++;
      if ({ram_en_out, ram_r_nw_out, ram_a_out} !== {2'b11, 17'h1FFFE}) begin
         errors++;
         $display("[TB] FAIL write_prime: got en=%b rnw=%b a=%h want en=1 rnw=1 a=1fffe", ram_en_out, ram_r_nw_out, ram_a_out);
      end
      for (int k = 0; k < 4; k++) begin
         @(negedge clk_in);
         ea = 17'(32'h1FFFE + k);
         eb = wd[8*k +: 8];
         checks++;
         if ({ram_en_out, ram_r_nw_out, ram_a_out, ram_d_out} !== {2'b10, ea, eb}) begin
            errors++;
            $display("[TB] FAIL write_byte k=%0d: got en=%b rnw=%b a=%h d=%h want en=1 rnw=0 a=%h d=%h",
                     k, ram_en_out, ram_r_nw_out, ram_a_out, ram_d_out, ea, eb);
         end
      end
      wait_done(8, at);
      ls_req_in = 1'b0;
      checks++;
      if (at != c0 + 6) begin
         errors++;
         $display("[TB] FAIL write_latency: got cycle %0d want %0d", at - c0, 6);
      end
      @(negedge clk_in);
      for (int k = 0; k < 4; k++) begin
         ea = 17'(32'h1FFFE + k);
         eb = wd[8*k +: 8];
         checks++;
         if (mem[ea] !== eb) begin
            errors++;
            $display("[TB] FAIL write_mem a=%h: got %h want %h", ea, mem[ea], eb);
         end
      end
      exp_q.push_back('{1'b1, 32'hDEAD_BEEF});
      applyStimulus(1'b1, 1'b0, 2'd2, 17'h1FFFE, 32'h0);
      c0 = cyc;
      wait_done(12, at);
      ls_req_in = 1'b0;
      checks++;
      if (at != c0 + 6) begin
         errors++;
         $display("[TB] FAIL readback_latency: got cycle %0d want %0d", at - c0, 6);
      end
      @(negedge clk_in);
   endtask

   task automatic test_byte_read();
      int c0;
      int at;
      poke(17'h3, 8'h80);
      poke(17'h4, 8'hFF);
      exp_q.push_back('{1'b1, 32'h0000_0080});
      applyStimulus(1'b1, 1'b0, 2'd0, 17'h3, 32'h0);
      c0 = cyc;
      wait_done(8, at);
      ls_req_in = 1'b0;
      checks++;
      if (at != c0 + 3) begin
         errors++;
         $display("[TB] FAIL byte_read_latency: got cycle %0d want %0d", at - c0, 3);
      end
      @(negedge clk_in);
   endtask

   task automatic test_arbitration();
      int at;
      rst_in = 1'b1;
      @(negedge clk_in);
      rst_in = 1'b0;
      poke(17'h20, 8'h11);
      poke(17'h21, 8'h22);
      poke(17'h22, 8'h33);
      poke(17'h23, 8'h44);
      poke(17'h30, 8'hA1);
      poke(17'h31, 8'hB2);
      exp_q.push_back('{1'b1, 32'h0000_B2A1});
`ifdef RAM_BUS_RR_EN
      exp_q.push_back('{1'b0, 32'h4433_2211});
`else
      exp_q.push_back('{1'b1, 32'h0000_B2A1});
`endif
      applyStimulus(1'b0, 1'b0, 2'd0, 17'h20, 32'h0);
      applyStimulus(1'b1, 1'b0, 2'd1, 17'h30, 32'h0);
      wait_done(10, at);
      checks++;
      if (at < 0 || ls_done_out !== 1'b1) begin
         errors++;
         $display("[TB] FAIL arb_first_owner: got ls_done=%b at=%0d want ls_done=1", ls_done_out, at);
      end
      wait_done(12, at);
      checks++;
`ifdef RAM_BUS_RR_EN
      if (at < 0 || if_done_out !== 1'b1) begin
         errors++;
         $display("[TB] FAIL arb_second_owner: got if_done=%b at=%0d want if_done=1", if_done_out, at);
      end
`else
      if (at < 0 || ls_done_out !== 1'b1) begin
         errors++;
         $display("[TB] FAIL arb_second_owner: got ls_done=%b at=%0d want ls_done=1", ls_done_out, at);
      end
`endif
      if_req_in = 1'b0;
      ls_req_in = 1'b0;
      @(negedge clk_in);
   endtask

   task automatic test_clear();
      int c0;
      int at;
      exp_q.push_back('{1'b1, 32'h0000_0080});
      applyStimulus(1'b0, 1'b0, 2'd0, 17'h20, 32'h0);
      c0 = cyc;
      @(negedge clk_in);
      applyStimulus(1'b1, 1'b0, 2'd0, 17'h3, 32'h0);
      @(negedge clk_in);
      checks++;
      if ({ram_en_out, ram_a_out} !== {1'b1, 17'h21}) begin
         errors++;
         $display("[TB] FAIL clr_pre_addr: got en=%b a=%h want en=1 a=00021", ram_en_out, ram_a_out);
      end
      if_clr_in = 1'b1;
      if_req_in = 1'b0;
      @(negedge clk_in);
      if_clr_in = 1'b0;
      checks++;
      if ({ram_en_out, if_done_out} !== 2'b00) begin
         errors++;
         $display("[TB] FAIL clr_idle: got en=%b if_done=%b want 0 0", ram_en_out, if_done_out);
      end
      @(negedge clk_in);
      checks++;
      if ({ram_en_out, ram_r_nw_out, ram_a_out} !== {2'b11, 17'h3}) begin
         errors++;
         $display("[TB] FAIL clr_ls_accept: got en=%b rnw=%b a=%h want en=1 rnw=1 a=00003", ram_en_out, ram_r_nw_out, ram_a_out);
      end
      wait_done(8, at);
      ls_req_in = 1'b0;
      checks++;
      if (at != c0 + 6) begin
         errors++;
         $display("[TB] FAIL clr_ls_latency: got cycle %0d want %0d", at - c0, 6);
      end
      @(negedge clk_in);
      if_req_in = 1'b1;
      if_clr_in = 1'b1;
      @(negedge clk_in);
      if_req_in = 1'b0;
      if_clr_in = 1'b0;
      checks++;
      if (ram_en_out !== 1'b0) begin
         errors++;
         $display("[TB] FAIL clr_ignores_idle_req: got en=%b want 0", ram_en_out);
      end
      @(negedge clk_in);
   endtask

   task automatic test_reset_mid_write();
      logic [7:0] want [4];
      want = '{8'h44, 8'h33, 8'h55, 8'h55};
      for (int k = 0; k < 4; k++) poke(17'(32'h40 + k), 8'h55);
      applyStimulus(1'b1, 1'b1, 2'd2, 17'h40, 32'h1122_3344);
      repeat (4) @(negedge clk_in);
      checks++;
      if ({ram_r_nw_out, ram_a_out} !== {1'b0, 17'h42}) begin
         errors++;
         $display("[TB] FAIL rst_mid_third_byte: got rnw=%b a=%h want rnw=0 a=00042", ram_r_nw_out, ram_a_out);
      end
      rst_in    = 1'b1;
      ls_req_in = 1'b0;
      @(negedge clk_in);
      checks++;
      if ({ram_en_out, ram_r_nw_out, ram_a_out, ram_d_out, if_done_out, ls_done_out, ls_rdata_out} !== {2'b01, 25'h0, 2'b00, 32'h0}) begin
         errors++;
         $display("[TB] FAIL rst_mid_outputs: got en=%b rnw=%b a=%h d=%h done=%b%b ls=%h want reset values",
                  ram_en_out, ram_r_nw_out, ram_a_out, ram_d_out, if_done_out, ls_done_out, ls_rdata_out);
      end
      rst_in = 1'b0;
      @(negedge clk_in);
      checks++;
      if ({ram_en_out, ls_done_out} !== 2'b00) begin
         errors++;
         $display("[TB] FAIL rst_mid_idle: got en=%b ls_done=%b want 0 0", ram_en_out, ls_done_out);
      end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (mem[17'(32'h40 + k)] !== want[k]) begin
            errors++;
            $display("[TB] FAIL rst_mid_mem byte %0d: got %h want %h", k, mem[17'(32'h40 + k)], want[k]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_if_read();
      test_write_wrap();
      test_byte_read();
      test_arbitration();
      test_clear();
      test_reset_mid_write();
      repeat (3) @(negedge clk_in);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("[TB] FAIL sb_leftover: got %0d pending completions want 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
